// File: rtl/vec_opb_seq_if.sv
// Bus bundle for the operand-B sequencer: issue handshake, VRF read port
// and ALU lane output. The sequencer uses the slave view.
interface vec_opb_seq_if #(
  parameter int VL_W   = 9,
  parameter int BEAT_W = 10
);
  logic              issue_valid;
  logic              issue_ready;
  logic [1:0]        issue_opsel;
  logic [VL_W-1:0]   issue_vl;
  logic [1:0]        issue_sew;
  logic [4:0]        issue_simm5;
  logic [31:0]       issue_scalar;
  logic [4:0]        issue_vs2;
  logic              rf_rd_req;
  logic [4:0]        rf_rd_addr;
  logic [BEAT_W-1:0] rf_rd_beat;
  logic [63:0]       rf_rd_data;
  logic              opb_valid;
  logic              opb_ready;
  logic [63:0]       opb_data;
  logic [7:0]        opb_bmask;
  logic              opb_last;
  logic              done;
  logic              err;
  logic              busy;

  modport slave (
    input  issue_valid, issue_opsel, issue_vl, issue_sew, issue_simm5,
           issue_scalar, issue_vs2, rf_rd_data, opb_ready,
    output issue_ready, rf_rd_req, rf_rd_addr, rf_rd_beat, opb_valid,
           opb_data, opb_bmask, opb_last, done, err, busy
  );

  modport master (
    output issue_valid, issue_opsel, issue_vl, issue_sew, issue_simm5,
           issue_scalar, issue_vs2, rf_rd_data, opb_ready,
    input  issue_ready, rf_rd_req, rf_rd_addr, rf_rd_beat, opb_valid,
           opb_data, opb_bmask, opb_last, done, err, busy
  );
endinterface

// File: rtl/vec_opb_seq.sv
// Operand-B sequencer for the vector ALU. Takes one instruction per issue
// handshake and streams operand B as 64-bit beats, either read from the VRF
// (VV) or as a SEW-replicated scalar/immediate broadcast (VX/VI).
// All outputs are registered from the next-state decode.
module vec_opb_seq #(
  parameter int VL_W   = 9,
  parameter int BEAT_W = 10
) (
  input logic           clk,
  input logic           rst,
  vec_opb_seq_if.slave  bus
);

  localparam int BY_W = VL_W + 4;

  localparam logic [1:0] OP_VV  = 2'b00;
  localparam logic [1:0] OP_VX  = 2'b01;
  localparam logic [1:0] OP_VI  = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [BEAT_W-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]        opsel_r, sew_r;
  logic [VL_W-1:0]   vl_r;
  logic [4:0]        vs2_r;

  logic              issue_ready_r, busy_r, rf_rd_req_r, opb_valid_r;
  logic              opb_last_r, done_r, err_r;
  logic [4:0]        rf_rd_addr_r;
  logic [BEAT_W-1:0] rf_rd_beat_r;
  logic [63:0]       opb_data_r;
  logic [7:0]        opb_bmask_r;

  logic              accept_s, hs_s, last_nxt_s;
  logic [1:0]        opsel_s, sew_s;
  logic [VL_W-1:0]   vl_s;
  logic [4:0]        vs2_s;
  logic [BY_W-1:0]   bytes_s;
  logic [BEAT_W-1:0] beats_s;
  logic [2:0]        rem_s;
  logic [63:0]       src_s, bcast_s;
  logic [7:0]        bmask_nxt_s;

  // Truncate a sign-extended source to SEW bits and tile it across 64 bits.
  function automatic logic [63:0] replicate_sew(input logic [63:0] src, input logic [1:0] sew);
    logic [63:0] res;
    case (sew)
      2'd0:    res = {8{src[7:0]}};
      2'd1:    res = {4{src[15:0]}};
      2'd2:    res = {2{src[31:0]}};
      2'd3:    res = src;
      default: res = src;
    endcase
    return res;
  endfunction

  // Operand selection (live issue fields while accepting, latched copy otherwise) and beat arithmetic.
  always_comb begin
    accept_s = bus.issue_valid && (state_r == S_IDLE);
    hs_s     = (state_r == S_OUT) && bus.opb_ready;
    if (accept_s) begin
      opsel_s = bus.issue_opsel;
      sew_s   = bus.issue_sew;
      vl_s    = bus.issue_vl;
      vs2_s   = bus.issue_vs2;
    end else begin
      opsel_s = opsel_r;
      sew_s   = sew_r;
      vl_s    = vl_r;
      vs2_s   = vs2_r;
    end
    bytes_s = {4'b0000, vl_s} << sew_s;
    beats_s = BEAT_W'((bytes_s + BY_W'(3'd7)) >> 3'd3);
    rem_s   = bytes_s[2:0];
    case (opsel_s)
      OP_VX:   src_s = {{32{bus.issue_scalar[31]}}, bus.issue_scalar};
      OP_VI:   src_s = {{59{bus.issue_simm5[4]}}, bus.issue_simm5};
      default: src_s = 64'd0;
    endcase
    bcast_s = replicate_sew(src_s, sew_s);
  end

  // Next-state and beat-counter decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          cnt_nxt_s = {BEAT_W{1'b0}};
          if (opsel_s == OP_BAD) begin
            state_nxt_s = S_FIN;
          end else if (vl_s == {VL_W{1'b0}}) begin
            state_nxt_s = S_FIN;
          end else if (opsel_s == OP_VV) begin
            state_nxt_s = S_RD;
          end else begin
            state_nxt_s = S_OUT;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RD:   state_nxt_s = S_WAIT;
      S_WAIT: state_nxt_s = S_OUT;
      S_OUT: begin
        if (hs_s) begin
          if (opb_last_r) begin
            state_nxt_s = S_FIN;
          end else begin
            cnt_nxt_s   = cnt_r + BEAT_W'(1'b1);
            state_nxt_s = (opsel_r == OP_VV) ? S_RD : S_OUT;
          end
        end else begin
          state_nxt_s = S_OUT;
        end
      end
      S_FIN:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Last-beat flag and byte mask for the beat about to be presented.
  always_comb begin
    last_nxt_s = (cnt_nxt_s == (beats_s - BEAT_W'(1'b1)));
    if (last_nxt_s && (rem_s != 3'd0)) begin
      bmask_nxt_s = (8'd1 << rem_s) - 8'd1;
    end else begin
      bmask_nxt_s = 8'hFF;
    end
  end

  // State register and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= {BEAT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Instruction fields latched on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      opsel_r <= 2'b00;
      sew_r   <= 2'b00;
      vl_r    <= {VL_W{1'b0}};
      vs2_r   <= 5'd0;
    end else if (accept_s) begin
      opsel_r <= bus.issue_opsel;
      sew_r   <= bus.issue_sew;
      vl_r    <= bus.issue_vl;
      vs2_r   <= bus.issue_vs2;
    end
  end

  // Registered outputs derived from the next state; opb_data holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_ready_r <= 1'b1;
      busy_r        <= 1'b0;
      rf_rd_req_r   <= 1'b0;
      rf_rd_addr_r  <= 5'd0;
      rf_rd_beat_r  <= {BEAT_W{1'b0}};
      opb_valid_r   <= 1'b0;
      opb_data_r    <= 64'd0;
      opb_bmask_r   <= 8'h00;
      opb_last_r    <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      issue_ready_r <= (state_nxt_s == S_IDLE);
      busy_r        <= (state_nxt_s != S_IDLE);
      rf_rd_req_r   <= (state_nxt_s == S_RD);
      rf_rd_addr_r  <= (state_nxt_s == S_RD) ? vs2_s : 5'd0;
      rf_rd_beat_r  <= (state_nxt_s == S_RD) ? cnt_nxt_s : {BEAT_W{1'b0}};
      opb_valid_r   <= (state_nxt_s == S_OUT);
      opb_bmask_r   <= (state_nxt_s == S_OUT) ? bmask_nxt_s : 8'h00;
      opb_last_r    <= (state_nxt_s == S_OUT) && last_nxt_s;
      done_r        <= (state_nxt_s == S_FIN);
      err_r         <= accept_s && (opsel_s == OP_BAD);
      if (accept_s && ((opsel_s == OP_VX) || (opsel_s == OP_VI))) begin
        opb_data_r <= bcast_s;
      end else if (state_r == S_WAIT) begin
        opb_data_r <= bus.rf_rd_data;
      end
    end
  end

  assign bus.issue_ready = issue_ready_r;
  assign bus.busy        = busy_r;
  assign bus.rf_rd_req   = rf_rd_req_r;
  assign bus.rf_rd_addr  = rf_rd_addr_r;
  assign bus.rf_rd_beat  = rf_rd_beat_r;
  assign bus.opb_valid   = opb_valid_r;
  assign bus.opb_data    = opb_data_r;
  assign bus.opb_bmask   = opb_bmask_r;
  assign bus.opb_last    = opb_last_r;
  assign bus.done        = done_r;
  assign bus.err         = err_r;

endmodule
